branch_perf_monitor: RTL and testbench

BRANCH_PERF_MONITOR -- requirements
Module: branch_perf_monitor

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_counter.sv | 59 +++++
 rtl/branch_perf_monitor.sv | 152 +++++++++++++++
 tb/tb_branch_perf_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the branch performance monitor.
//   perf_state_e : run/halt state of the monitor FSM
//   DEF_*        : default widths used by the top and counter modules
//   CYC_*_SEL    : readout index offsets for the cycle-counter snapshot,
//                  counted past the last event index (index = NUM_EVT + offset)
//   sel_width()  : width of the readout index for a given event count
package perf_pkg;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } perf_state_e;

  localparam int DEF_NUM_EVT = 2;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_CYC_W   = 64;

  localparam int CYC_LO_SEL  = 0;
  localparam int CYC_HI_SEL  = 1;

  function automatic int sel_width(input int num_evt);
    return $clog2(num_evt + 2);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : zero count and overflow flag (wins over inc)
//   count      : current count
//   ovf        : sticky overflow flag
// SATURATE=0 wraps all-ones -> 0 and flags on the wrap edge.
// SATURATE=1 holds at all-ones and flags on the edge that reaches it.
module perf_counter
  import perf_pkg::*;
#(
  parameter int W        = DEF_CNT_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if (count_q == MAX) begin
        // At all-ones: saturating mode holds, wrapping mode rolls to 0.
        if (!SATURATE) count_d = '0;
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
        if (SATURATE && (count_q == (MAX - 1'b1))) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/branch_perf_monitor.sv
// Branch performance monitor: counts mispredict events on committed
// branches plus run cycles, with snapshot bank and one-cycle readout.
//   clk, rst_n           : clock, asynchronous active-low reset
//   commit_i             : branch commit qualifier
//   evt_i[NUM_EVT]       : per-event pulses (counted only with commit_i)
//   start_i / stop_i     : HALT->RUN / RUN->HALT (stop wins)
//   clear_i              : zero live counters and overflow flags
//   snap_i               : copy live counters into the snapshot bank
//   rd_req_i, rd_sel_i   : readout request and snapshot index
//   rd_valid_o, rd_data_o: readout result, one cycle after the request
//   ovf_o[NUM_EVT]       : sticky overflow flags
//   running_o            : FSM is in RUN
module branch_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT   = DEF_NUM_EVT,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int CYC_W     = DEF_CYC_W,
  parameter bit SATURATE  = 1'b0,
  parameter bit START_RUN = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                commit_i,
  input  logic [NUM_EVT-1:0]                  evt_i,
  input  logic                                start_i,
  input  logic                                stop_i,
  input  logic                                clear_i,
  input  logic                                snap_i,
  input  logic                                rd_req_i,
  input  logic [sel_width(NUM_EVT)-1:0]       rd_sel_i,
  output logic                                rd_valid_o,
  output logic [CNT_W-1:0]                    rd_data_o,
  output logic [NUM_EVT-1:0]                  ovf_o,
  output logic                                running_o
);

  localparam int          SEL_W     = sel_width(NUM_EVT);
  localparam perf_state_e RST_STATE = START_RUN ? RUN : HALT;

  perf_state_e state_q, state_d;

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] evt_cnt    [NUM_EVT];
  logic [CNT_W-1:0] snap_evt_q [NUM_EVT];
  logic [CNT_W-1:0] snap_evt_d [NUM_EVT];
  logic [CYC_W-1:0] snap_cyc_q, snap_cyc_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] sel_data;
  logic             run;

  // Run/halt FSM
  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = HALT;
    end else if (start_i) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  assign run       = (state_q == RUN);
  assign running_o = run;

  // Event counters; clear suppresses any increment in the same cycle.
  for (genvar k = 0; k < NUM_EVT; k++) begin : gen_evt
    perf_counter #(
      .W        (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (run && commit_i && evt_i[k] && !clear_i),
      .clr   (clear_i),
      .count (evt_cnt[k]),
      .ovf   (ovf_o[k])
    );
  end

  // Cycle counter always wraps.
  always_comb begin
    cyc_d = cyc_q;
    if (clear_i) begin
      cyc_d = '0;
    end else if (run) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // Snapshot bank captures pre-edge live values.
  always_comb begin
    snap_cyc_d = snap_cyc_q;
    for (int k = 0; k < NUM_EVT; k++) begin
      snap_evt_d[k] = snap_evt_q[k];
    end
    if (snap_i) begin
      snap_cyc_d = cyc_q;
      for (int k = 0; k < NUM_EVT; k++) begin
        snap_evt_d[k] = evt_cnt[k];
      end
    end
  end

  // Readout mux reads the current snapshot, so a same-cycle snap is not seen.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) sel_data = snap_evt_q[k];
    end
    if (rd_sel_i == SEL_W'(NUM_EVT + CYC_LO_SEL)) begin
      sel_data = CNT_W'(snap_cyc_q);
    end
    if (rd_sel_i == SEL_W'(NUM_EVT + CYC_HI_SEL)) begin
      sel_data = CNT_W'(snap_cyc_q >> CNT_W);
    end
  end

  always_comb begin
    rd_valid_d = rd_req_i;
    rd_data_d  = rd_req_i ? sel_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q      <= '0;
      snap_cyc_q <= '0;
      for (int k = 0; k < NUM_EVT; k++) begin
        snap_evt_q[k] <= '0;
      end
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cyc_q      <= cyc_d;
      snap_cyc_q <= snap_cyc_d;
      for (int k = 0; k < NUM_EVT; k++) begin
        snap_evt_q[k] <= snap_evt_d[k];
      end
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_branch_perf_monitor.sv
// Bench for branch_perf_monitor: three instances share one stimulus stream
// (32-bit wrapping, 4-bit wrapping, 4-bit saturating) and are compared each
// cycle against a model that keeps unbounded event/cycle totals and derives
// the visible values from them.
module tb_branch_perf_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       commit, start, stop, clear, snap, rd_req;
  logic [1:0] evt, rd_sel;

  logic        rv   [3];
  logic        runo [3];
  logic [1:0]  ovf  [3];
  logic [31:0] rd0;
  logic [3:0]  rd1, rd2;

  branch_perf_monitor #(.NUM_EVT(2), .CNT_W(32), .CYC_W(64), .SATURATE(1'b0), .START_RUN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .commit_i(commit), .evt_i(evt), .start_i(start), .stop_i(stop),
    .clear_i(clear), .snap_i(snap), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_valid_o(rv[0]), .rd_data_o(rd0), .ovf_o(ovf[0]), .running_o(runo[0]));

  branch_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .CYC_W(8), .SATURATE(1'b0), .START_RUN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .commit_i(commit), .evt_i(evt), .start_i(start), .stop_i(stop),
    .clear_i(clear), .snap_i(snap), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_valid_o(rv[1]), .rd_data_o(rd1), .ovf_o(ovf[1]), .running_o(runo[1]));

  branch_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .CYC_W(8), .SATURATE(1'b1), .START_RUN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .commit_i(commit), .evt_i(evt), .start_i(start), .stop_i(stop),
    .clear_i(clear), .snap_i(snap), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_valid_o(rv[2]), .rd_data_o(rd2), .ovf_o(ovf[2]), .running_o(runo[2]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: totals since the last clear/reset, independent of width.
  longint unsigned ev_tot [2];
  longint unsigned cyc_tot;
  longint unsigned snap_ev [2];
  longint unsigned snap_cyc;
  bit              m_run;
  bit              exp_rv;
  longint unsigned exp_rd [3];

  function automatic int pw(input int i);   return (i == 0) ? 32 : 4; endfunction
  function automatic int pcw(input int i);  return (i == 0) ? 64 : 8; endfunction
  function automatic bit psat(input int i); return (i == 2);          endfunction

  function automatic longint unsigned msk(input int w);
    if (w >= 64) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint unsigned ev_view(input int i, input longint unsigned t);
    longint unsigned m = msk(pw(i));
    if (psat(i)) return (t > m) ? m : t;
    return t & m;
  endfunction

  function automatic logic [1:0] ovf_exp(input int i);
    logic [1:0] r;
    longint unsigned m = msk(pw(i));
    for (int k = 0; k < 2; k++) r[k] = psat(i) ? (ev_tot[k] >= m) : (ev_tot[k] > m);
    return r;
  endfunction

  function automatic longint unsigned rd_exp(input int i, input logic [1:0] sel);
    longint unsigned c = snap_cyc & msk(pcw(i));
    case (sel)
      2'd0:    return ev_view(i, snap_ev[0]);
      2'd1:    return ev_view(i, snap_ev[1]);
      2'd2:    return c & msk(pw(i));
      default: return (c >> pw(i)) & msk(pw(i));
    endcase
  endfunction

  function automatic logic [63:0] rd_obs(input int i);
    case (i)
      0:       return {32'd0, rd0};
      1:       return {60'd0, rd1};
      default: return {60'd0, rd2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_running", i), {63'd0, runo[i]}, {63'd0, m_run});
      chk($sformatf("d%0d_ovf", i),     {62'd0, ovf[i]},  {62'd0, ovf_exp(i)});
      chk($sformatf("d%0d_rd_valid", i), {63'd0, rv[i]},  {63'd0, exp_rv});
      chk($sformatf("d%0d_rd_data", i), rd_obs(i),        exp_rd[i]);
    end
  endtask

  task automatic model_reset();
    ev_tot   = '{0, 0};
    snap_ev  = '{0, 0};
    cyc_tot  = 0;
    snap_cyc = 0;
    m_run    = 1'b1;
    exp_rv   = 1'b0;
    exp_rd   = '{0, 0, 0};
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic cycle();
    bit              nrv;
    longint unsigned nrd [3];
    nrv = rd_req;
    for (int i = 0; i < 3; i++) nrd[i] = rd_req ? rd_exp(i, rd_sel) : 64'd0;
    if (snap) begin
      snap_ev  = ev_tot;
      snap_cyc = cyc_tot;
    end
    if (clear) begin
      ev_tot  = '{0, 0};
      cyc_tot = 0;
    end else if (m_run) begin
      cyc_tot++;
      for (int k = 0; k < 2; k++) if (commit && evt[k]) ev_tot[k]++;
    end
    if (stop) m_run = 1'b0;
    else if (start) m_run = 1'b1;
    @(posedge clk);
    #1;
    exp_rv = nrv;
    exp_rd = nrd;
    check_outs();
  endtask

  task automatic idle();
    commit = 1'b0; evt = 2'b00; start = 1'b0; stop = 1'b0;
    clear = 1'b0; snap = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;
  endtask

  task automatic pulse_clear(); clear = 1'b1; cycle(); clear = 1'b0; endtask
  task automatic pulse_snap();  snap = 1'b1;  cycle(); snap = 1'b0;  endtask

  task automatic read(input logic [1:0] sel);
    rd_req = 1'b1; rd_sel = sel; cycle(); rd_req = 1'b0; rd_sel = 2'd0;
  endtask

  task automatic events(input logic [1:0] e, input logic c, input int n);
    commit = c; evt = e;
    repeat (n) cycle();
    commit = 1'b0; evt = 2'b00;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    check_outs();
    #5 rst_n = 1'b1;

    // Two event streams counted independently.
    pulse_clear();
    events(2'b01, 1'b1, 5);
    events(2'b10, 1'b1, 3);
    pulse_snap();
    read(2'd0); chk("basic_evt0", {32'd0, rd0}, 64'd5);
    read(2'd1); chk("basic_evt1", {32'd0, rd0}, 64'd3);

    // 17 events on 4-bit counters: wrap to 1 vs saturate at 15.
    pulse_clear();
    events(2'b01, 1'b1, 17);
    pulse_snap();
    read(2'd0);
    chk("wrap_cnt", {60'd0, rd1}, 64'd1);
    chk("sat_cnt",  {60'd0, rd2}, 64'd15);
    chk("wrap_ovf", {63'd0, ovf[1][0]}, 64'd1);
    chk("sat_ovf",  {63'd0, ovf[2][0]}, 64'd1);

    // Events without commit are ignored; halted cycles are not counted.
    pulse_clear();
    events(2'b11, 1'b0, 10);
    pulse_snap();
    read(2'd0); chk("nocommit_evt0", {32'd0, rd0}, 64'd0);
    read(2'd1); chk("nocommit_evt1", {32'd0, rd0}, 64'd0);
    pulse_clear();
    repeat (5) cycle();
    stop = 1'b1; repeat (4) cycle(); stop = 1'b0;
    chk("halted", {63'd0, runo[0]}, 64'd0);
    start = 1'b1; cycle(); start = 1'b0;
    repeat (2) cycle();
    pulse_snap();
    read(2'd2); chk("cyc_lo", {32'd0, rd0}, 64'd8);
    read(2'd3); chk("cyc_hi", {32'd0, rd0}, 64'd0);

    // Snap and clear together keep the pre-clear value.
    pulse_clear();
    events(2'b01, 1'b1, 7);
    snap = 1'b1; clear = 1'b1; cycle(); snap = 1'b0; clear = 1'b0;
    read(2'd0); chk("snapclr_old", {32'd0, rd0}, 64'd7);
    pulse_snap();
    read(2'd0); chk("snapclr_new", {32'd0, rd0}, 64'd0);

    // Start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    chk("startstop", {63'd0, runo[0]}, 64'd0);
    start = 1'b1; cycle(); start = 1'b0;

    // Reset mid-count with a readout request outstanding.
    pulse_clear();
    events(2'b11, 1'b1, 9);
    pulse_snap();
    rd_req = 1'b1; rd_sel = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("rst_running", {63'd0, runo[0]}, 64'd1);
    idle();
    @(posedge clk);
    #1;
    check_outs();
    #2 rst_n = 1'b1;
    cycle();
    chk("rst_no_valid", {63'd0, rv[0]}, 64'd0);
    read(2'd0); chk("rst_snap0", {32'd0, rd0}, 64'd0);
    read(2'd1); chk("rst_snap1", {32'd0, rd0}, 64'd0);

    // Randomized traffic.
    repeat (3000) begin
      commit = ($urandom_range(0, 3) != 0);
      evt    = 2'($urandom);
      start  = ($urandom_range(0, 15) == 0);
      stop   = ($urandom_range(0, 19) == 0);
      clear  = ($urandom_range(0, 59) == 0);
      snap   = ($urandom_range(0, 7) == 0);
      rd_req = ($urandom_range(0, 1) == 0);
      rd_sel = 2'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
